ldpc_3gpp_dec_llr_read_ctrl: RTL

- Read sequencer that sits directly upstream of the LLR read address generator.
- Drives the generator's read strobe, frame/packet strobes, lane masks and start pulse for one LLR frame walk.
- Cnode pass walks horizontally: rows outer, zc inner, one packet per row.
- Vnode pass walks vertically: zc outer, rows inner, one packet per zc step.
- Walk mode, lifting size and row geometry are latched on start; the block supports stall and signals completion.

---
 rtl/ldpc_3gpp_dec_llr_read_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ldpc_3gpp_dec_llr_read_ctrl.sv
// LLR read sequencer: walks one LLR frame (cnode = rows outer / zc inner,
// vnode = zc outer / rows inner) and drives read strobe, frame/packet strobes and lane mask.
// Latency: first read registered one cycle after the RUN state is entered; ihold/iclkena stall without skipping reads.
// Optional inter-packet gap (igap port) is built when LDPC_3GPP_DEC_LLR_RCTRL_GAP_EN is defined.
module ldpc_3gpp_dec_llr_read_ctrl #(
    parameter int pZC_W        = 9,
    parameter int pROW_W       = 6,
    parameter int pROW_BY_CYCLE = 8,
    localparam int LANE_W      = $clog2(pROW_BY_CYCLE) + 1,
    localparam int CNT_W       = (pZC_W > pROW_W) ? pZC_W : pROW_W
) (
    input  logic                     iclk,
    input  logic                     ireset,
    input  logic                     iclkena,
    input  logic                     istart,
    input  logic                     ic_nv_mode,
    input  logic [pZC_W-1:0]         iused_zc,
    input  logic [pROW_W-1:0]        iused_row,
    input  logic [LANE_W-1:0]        ilast_lanes,
    input  logic                     ihold,
`ifdef LDPC_3GPP_DEC_LLR_RCTRL_GAP_EN
    input  logic [3:0]               igap,
`endif
    output logic                     oread,
    output logic                     orstart,
    output logic                     orval,
    output logic [3:0]               orstrb,
    output logic [pROW_BY_CYCLE-1:0] ormask,
    output logic                     obusy,
    output logic                     odone
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t state, state_nxt;

    // frame parameters captured on start
    logic                c_nv_q;
    logic [pZC_W-1:0]    zc_q;
    logic [pROW_W-1:0]   nrow_q;
    logic [LANE_W-1:0]   lanes_q;

    // walk counters: o = outer, i = inner
    logic [CNT_W-1:0]    o_cnt, o_nxt;
    logic [CNT_W-1:0]    i_cnt, i_nxt;

    logic                load;
    logic                read_nxt;
    logic                rstart_nxt;
    logic [3:0]          strb_nxt;
    logic [pROW_BY_CYCLE-1:0] mask_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    logic [CNT_W-1:0]    zc_last;
    logic [CNT_W-1:0]    nrow_last;
    logic [CNT_W-1:0]    o_last;
    logic [CNT_W-1:0]    i_last;
    logic [CNT_W-1:0]    row_cur;
    logic                i_at_last;
    logic                o_at_last;
    logic                i_at_first;
    logic                o_at_first;
    logic [pROW_BY_CYCLE-1:0] lane_mask;

`ifdef LDPC_3GPP_DEC_LLR_RCTRL_GAP_EN
    logic [3:0]          gap_q;
    logic [3:0]          gap_cnt, gap_nxt;
`endif

    // walk geometry derived from the latched frame parameters
    always_comb begin
        zc_last    = CNT_W'(zc_q) - ONE;
        nrow_last  = CNT_W'(nrow_q) - ONE;
        o_last     = c_nv_q ? nrow_last : zc_last;
        i_last     = c_nv_q ? zc_last : nrow_last;
        row_cur    = c_nv_q ? o_cnt : i_cnt;
        i_at_last  = (i_cnt == i_last);
        o_at_last  = (o_cnt == o_last);
        i_at_first = (i_cnt == '0);
        o_at_first = (o_cnt == '0);
    end

    // lane mask: only the last row of a line may be partially populated
    always_comb begin
        lane_mask = '1;
        if ((row_cur == nrow_last) && (lanes_q != '0)) begin
            for (int l = 0; l < pROW_BY_CYCLE; l++) begin
                lane_mask[l] = (LANE_W'(l) < lanes_q);
            end
        end
    end

    // next-state, counter advance and next output values
    always_comb begin
        state_nxt  = state;
        o_nxt      = o_cnt;
        i_nxt      = i_cnt;
        load       = 1'b0;
        read_nxt   = 1'b0;
        rstart_nxt = 1'b0;
        strb_nxt   = 4'b0000;
        mask_nxt   = ormask;
        busy_nxt   = obusy;
        done_nxt   = 1'b0;
`ifdef LDPC_3GPP_DEC_LLR_RCTRL_GAP_EN
        gap_nxt    = gap_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (istart) begin
                    state_nxt = S_RUN;
                    load      = 1'b1;
                    o_nxt     = '0;
                    i_nxt     = '0;
                    busy_nxt  = 1'b1;
`ifdef LDPC_3GPP_DEC_LLR_RCTRL_GAP_EN
                    gap_nxt   = 4'd0;
`endif
                end
            end
            S_RUN: begin
`ifdef LDPC_3GPP_DEC_LLR_RCTRL_GAP_EN
                if (gap_cnt != 4'd0) begin
                    // gap cycles ignore ihold and only count down
                    gap_nxt = gap_cnt - 4'd1;
                end else
`endif
                if (!ihold) begin
                    read_nxt   = 1'b1;
                    rstart_nxt = o_at_first && i_at_first;
                    strb_nxt   = {o_at_first && i_at_first, i_at_first,
                                  i_at_last, o_at_last && i_at_last};
                    mask_nxt   = lane_mask;
                    if (o_at_last && i_at_last) begin
                        state_nxt = S_DONE;
                        o_nxt     = '0;
                        i_nxt     = '0;
                    end else if (i_at_last) begin
                        i_nxt = '0;
                        o_nxt = o_cnt + ONE;
`ifdef LDPC_3GPP_DEC_LLR_RCTRL_GAP_EN
                        gap_nxt = gap_q;
`endif
                    end else begin
                        i_nxt = i_cnt + ONE;
                    end
                end
            end
            S_DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // state, counters and registered outputs; pulses drop while the clock enable is low
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state   <= S_IDLE;
            o_cnt   <= '0;
            i_cnt   <= '0;
            c_nv_q  <= 1'b0;
            zc_q    <= '0;
            nrow_q  <= '0;
            lanes_q <= '0;
            oread   <= 1'b0;
            orstart <= 1'b0;
            orval   <= 1'b0;
            orstrb  <= 4'b0000;
            ormask  <= '0;
            obusy   <= 1'b0;
            odone   <= 1'b0;
`ifdef LDPC_3GPP_DEC_LLR_RCTRL_GAP_EN
            gap_q   <= 4'd0;
            gap_cnt <= 4'd0;
`endif
        end else if (iclkena) begin
            state   <= state_nxt;
            o_cnt   <= o_nxt;
            i_cnt   <= i_nxt;
            oread   <= read_nxt;
            orstart <= rstart_nxt;
            orval   <= read_nxt;
            orstrb  <= strb_nxt;
            ormask  <= mask_nxt;
            obusy   <= busy_nxt;
            odone   <= done_nxt;
`ifdef LDPC_3GPP_DEC_LLR_RCTRL_GAP_EN
            gap_cnt <= gap_nxt;
`endif
            if (load) begin
                c_nv_q  <= ic_nv_mode;
                zc_q    <= (iused_zc == '0) ? pZC_W'(1) : iused_zc;
                nrow_q  <= (iused_row == '0) ? pROW_W'(1) : iused_row;
                lanes_q <= ilast_lanes;
`ifdef LDPC_3GPP_DEC_LLR_RCTRL_GAP_EN
                gap_q   <= igap;
`endif
            end
        end else begin
            oread   <= 1'b0;
            orstart <= 1'b0;
            orval   <= 1'b0;
            orstrb  <= 4'b0000;
            odone   <= 1'b0;
        end
    end

endmodule
